// File: rtl/input_conditioner.sv
// Per-channel synchroniser, debounce counter and registered edge pulses for
// mechanical switches and buttons sampled on a single clock.
module input_conditioner #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] switches_input,
   output logic [WIDTH-1:0] stable_output,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Pure flop-to-flop chain: nothing may sit between metastability stages.
   always_comb begin
      sync_d[0] = switches_input;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   always_comb begin
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_s[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = sync_s[i];
               rise_d[i]   = sync_s[i];
               fall_d[i]   = ~sync_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign stable_output = stable_q;
   assign rise_pulse    = rise_q;
   assign fall_pulse    = fall_q;
   assign any_change    = |(rise_q | fall_q);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a run-length
// reference model of the debounce rules (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_conditioner;

   localparam int W    = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw  = '0;
   logic [W-1:0] stable_output;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;
   logic         any_change;

   int tests    = 0;
   int failures = 0;

   // Reference model: input delay line, accepted level and length of the
   // current uninterrupted disagreement run per channel.
   logic [W-1:0] pipe[$];
   logic [W-1:0] m_stable;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   int           run[W];

   input_conditioner #(
      .WIDTH          (W),
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .switches_input(sw),
      .stable_output (stable_output),
      .rise_pulse    (rise_pulse),
      .fall_pulse    (fall_pulse),
      .any_change    (any_change)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      pipe.delete();
      for (int k = 0; k < SYNC; k++) pipe.push_back('0);
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
   endtask

   task automatic modelStep(input logic [W-1:0] in, input logic r);
      logic [W-1:0] s_old;
      if (r) begin
         modelReset();
      end else begin
         s_old = pipe.pop_front();
         pipe.push_back(in);
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < W; i++) begin
            if (s_old[i] == m_stable[i]) begin
               run[i] = 0;
            end else begin
               run[i] = run[i] + 1;
               if (run[i] == DEB) begin
                  m_stable[i] = s_old[i];
                  run[i]      = 0;
                  if (s_old[i]) m_rise[i] = 1'b1;
                  else          m_fall[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, "_stable"}, stable_output, m_stable);
      checkValue({tag, "_rise"}, rise_pulse, m_rise);
      checkValue({tag, "_fall"}, fall_pulse, m_fall);
      checkValue({tag, "_any"}, {3'b000, any_change}, {3'b000, |(m_rise | m_fall)});
      checkValue({tag, "_excl"}, rise_pulse & fall_pulse, 4'b0000);
   endtask

   // Drive one clock's worth of input, then compare after the edge settles.
   task automatic applyStimulus(input logic [W-1:0] in, input logic r, input string tag);
      sw  = in;
      rst = r;
      @(posedge clk);
      #1;
      modelStep(in, r);
      checkOutput(tag);
   endtask

   initial begin
      logic [12:0] bounce_seq;
      logic [W-1:0] cur;
      logic         r;
      int           rise2_count;
      int           rise2_at;

      modelReset();

      applyStimulus(4'b0000, 1'b1, "reset");
      applyStimulus(4'b0000, 1'b1, "reset");
      checkValue("reset_outputs", stable_output | rise_pulse | fall_pulse, 4'b0000);

      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'b0001, 1'b0, "clean_rise");
         if (k == 5) checkValue("rise_not_early", stable_output, 4'b0000);
         if (k == 6) begin
            checkValue("rise_stable_e6", stable_output, 4'b0001);
            checkValue("rise_pulse_e6", rise_pulse, 4'b0001);
            checkValue("rise_any_e6", {3'b000, any_change}, 4'b0001);
         end
         if (k == 7) begin
            checkValue("rise_pulse_e7", rise_pulse, 4'b0000);
            checkValue("rise_any_e7", {3'b000, any_change}, 4'b0000);
         end
      end

      for (int k = 0; k < 11; k++) begin
         applyStimulus((k < 3) ? 4'b0011 : 4'b0001, 1'b0, "glitch");
         checkValue("glitch_bit1", (stable_output | rise_pulse | fall_pulse) & 4'b0010, 4'b0000);
      end

      bounce_seq  = 13'b1111111111011;
      rise2_count = 0;
      rise2_at    = -1;
      for (int k = 0; k < 13; k++) begin
         applyStimulus({1'b0, bounce_seq[k], 2'b01}, 1'b0, "bounce");
         if (rise_pulse[2]) begin
            rise2_count++;
            if (rise2_at < 0) rise2_at = k;
         end
      end
      checkValue("bounce_count", 4'(rise2_count), 4'd1);
      checkValue("bounce_when", 4'(rise2_at), 4'd8);

      for (int k = 1; k <= 8; k++) applyStimulus(4'b0110, 1'b0, "simul_setup");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'b1101, 1'b0, "simul");
         if (k == 6) begin
            checkValue("simul_rise", rise_pulse, 4'b1001);
            checkValue("simul_fall", fall_pulse, 4'b0010);
            checkValue("simul_stable", stable_output, 4'b1101);
         end
         if (k == 7) checkValue("simul_after", rise_pulse | fall_pulse, 4'b0000);
      end

      for (int k = 1; k <= 8; k++) applyStimulus(4'b0000, 1'b0, "rstmid_setup");
      for (int k = 1; k <= 3; k++) applyStimulus(4'b0001, 1'b0, "rstmid_count");
      applyStimulus(4'b0001, 1'b1, "rstmid_reset");
      checkValue("rstmid_cleared", stable_output | rise_pulse | fall_pulse, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'b0001, 1'b0, "rstmid_release");
         if (k == 5) checkValue("rstmid_not_early", rise_pulse, 4'b0000);
         if (k == 6) checkValue("rstmid_rise", rise_pulse, 4'b0001);
      end

      for (int k = 1; k <= 8; k++) applyStimulus(4'b1111, 1'b0, "fall_setup");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'b0000, 1'b0, "fall");
         if (k == 6) begin
            checkValue("fall_pulse_e6", fall_pulse, 4'b1111);
            checkValue("fall_stable_e6", stable_output, 4'b0000);
         end
         if (k == 7) checkValue("fall_pulse_e7", fall_pulse, 4'b0000);
      end

      cur = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 4) == 0) cur[i] = ~cur[i];
         end
         r = ($urandom_range(0, 99) == 0);
         applyStimulus(cur, r, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of independent input channels (switches/buttons).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser flop depth per channel; legal range 2..4.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), giving the consecutive clocks a new level must persist; legal range >= 1.
REQ-004 The block SHALL size its internal counter width as max(1, clog2(DEBOUNCE_CYCLES)).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port switches_input, input, WIDTH bits, asynchronous raw channel levels.
REQ-008 The block SHALL have port stable_output, output, WIDTH bits, debounced level per channel.
REQ-009 The block SHALL have port rise_pulse, output, WIDTH bits, a one-clock pulse when stable_output[i] goes 0->1.
REQ-010 The block SHALL have port fall_pulse, output, WIDTH bits, a one-clock pulse when stable_output[i] goes 1->0.
REQ-011 The block SHALL have port any_change, output, 1 bit, equal to the OR of all rise_pulse and fall_pulse bits (combinational from registers).

Function
REQ-012 Each channel SHALL pass through a SYNC_STAGES-deep flop chain; s[i] denotes the last stage, and no logic SHALL sit between stages.
REQ-013 Each channel SHALL own an independent counter cnt[i]; channels SHALL NOT share or influence state.
REQ-014 Per edge, when s[i] == stable_output[i], the block SHALL load cnt[i] with 0, and stable_output[i] SHALL hold.
REQ-015 Per edge, when s[i] != stable_output[i] and cnt[i] < DEBOUNCE_CYCLES-1, the block SHALL increment cnt[i].
REQ-016 Per edge, when s[i] != stable_output[i] and cnt[i] == DEBOUNCE_CYCLES-1, the block SHALL load stable_output[i] with s[i], load cnt[i] with 0, and assert rise_pulse[i] = s[i] and fall_pulse[i] = ~s[i].
REQ-017 rise_pulse and fall_pulse SHALL be registered, default 0 every cycle, and high for exactly one clock coincident with the first cycle of the new stable_output value.
REQ-018 Latency: for a clean input change held from before edge 1, stable_output SHALL change after edge SYNC_STAGES+DEBOUNCE_CYCLES (2+1=3 with DEBOUNCE_CYCLES=1).
REQ-019 Glitch rejection: an s[i] excursion shorter than DEBOUNCE_CYCLES clocks SHALL produce no change on stable_output[i] and no pulse; the counter SHALL restart from 0 on return.
REQ-020 Bounce: any return of s[i] to the stable level SHALL restart the count; only an uninterrupted run of DEBOUNCE_CYCLES clocks SHALL be accepted.
REQ-021 With DEBOUNCE_CYCLES = 1, the block SHALL reduce to synchroniser plus edge detector (update on the first edge that sees a difference).
REQ-022 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-023 Multiple channels completing on the same edge SHALL each assert their own pulse in the same cycle; any_change SHALL be a single 1-cycle high.
REQ-024 rise_pulse[i] and fall_pulse[i] SHALL never be high simultaneously.

Reset
REQ-025 On a clk edge with rst = 1, the block SHALL clear all sync stages, cnt, stable_output, rise_pulse and fall_pulse to 0, overriding all other behaviour; any_change SHALL therefore be 0.
REQ-026 Reset mid-count SHALL discard partial counts; counting SHALL restart from 0 on the first edge with rst = 0.
REQ-027 An input held at 1 through reset SHALL yield rise_pulse after the normal latency following reset release.

Verification (bench parameters: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-028 Clean rise: switches_input 0000->0001, held from before edge 1 -> stable_output=0001 and rise_pulse=0001 first visible after edge 6, rise_pulse=0000 after edge 7, any_change high for that one cycle only.
REQ-029 Glitch: bit 1 high for 3 clocks, then low -> stable_output, rise_pulse and fall_pulse remain 0000 throughout.
REQ-030 Bounce: bit 2 sequence 1,1,0,1,1,1,1 (one value per clock) -> a single rise_pulse[2], occurring 4 clocks after the final 1-run begins at s[2], with no earlier pulse.
REQ-031 Simultaneous: bits 0 and 3 rise on the same edge while bit 1 is already stable high and then falls -> rise_pulse=1001 in one cycle, fall_pulse[1] pulses independently, and each channel's timing is per REQ-018.
REQ-032 Reset mid-count: bit 0 high for 2 clocks at s[0], then rst for 1 clock -> all outputs 0000; with input still high, rise_pulse[0] occurs SYNC_STAGES+DEBOUNCE_CYCLES edges after release.
REQ-033 Fall: from stable 1111, drive 0000 -> fall_pulse=1111 for exactly one clock at the REQ-018 latency, and stable_output=0000.
